// File: rtl/ifu_pkg.sv
// ifu_pkg: shared widths, reset PC, NOP encoding and fetch state for the fetch unit
package ifu_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] PcRst = 64'h8000_0000;
  localparam logic [XLEN-1:0] RESET_PC = PcRst;
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;
  typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_e;
endpackage

// File: rtl/ifu_pc_gen.sv
// ifu_pc_gen: fetch PC register with hold / +4 / redirect next-PC selection
module ifu_pc_gen
  import ifu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            advance,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] fpc
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fpc <= RESET_PC;
    else fpc <= redirect_valid ? redirect_pc : advance ? fpc + XLEN'(4) : fpc;
endmodule

// File: rtl/ifu.sv
// ifu: instruction fetch unit; drives the ROM address and holds the IF/ID register
module ifu
  import ifu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] rom_pc,
  input  logic [ILEN-1:0] rom_inst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [ILEN-1:0] id_inst,
  output logic            id_misaligned,
  output logic [31:0]     fetch_cnt
);
  fetch_state_e state, state_nxt;
  logic [XLEN-1:0] fpc;
  logic load, misaligned;
  ifu_pc_gen u_pc_gen (
    .clk(clk),
    .rst_n(rst_n),
    .advance(load),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .fpc(fpc)
  );
  assign rom_pc = fpc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= BOOT;
    else state <= state_nxt;
  always_comb
    state_nxt = redirect_valid ? RUN :
                state == BOOT ? RUN :
                (load && misaligned) ? HALT : state;
  always_comb begin
    load = (state == RUN) && (!id_valid || id_ready) && !redirect_valid;
    misaligned = fpc[1:0] != 2'b00;
  end
  // a redirect flushes the held entry even when decode takes it the same cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      id_valid      <= 1'b0;
      id_pc         <= '0;
      id_inst       <= NOP;
      id_misaligned <= 1'b0;
      fetch_cnt     <= '0;
    end else if (redirect_valid) begin
      id_valid <= 1'b0;
    end else if (load) begin
      id_valid      <= 1'b1;
      id_pc         <= fpc;
      id_inst       <= misaligned ? NOP : rom_inst;
      id_misaligned <= misaligned;
      fetch_cnt     <= fetch_cnt + 32'd1;
    end else if (state != RUN && id_valid && id_ready) begin
      id_valid <= 1'b0;
    end
endmodule
